// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] WMASK_READ = 4'b0000;

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner select. Round-robin by default; defining MEM_ARB_FIXED_PRIO_EN
// makes port 0 win every tie. winner = 0 selects port 0, 1 selects port 1.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic winner
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign winner = !req0 && req1;
`else
  // On a tie the port that was not served last time wins.
  assign winner = (req0 && req1) ? !last_grant : req1;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between two req/ready requesters.
// Tie-break is round-robin unless MEM_ARB_FIXED_PRIO_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [31:0]           p0_wdata,
  input  logic [3:0]            p0_wmask,
  output logic                  p0_ready,
  input  logic                  p1_req,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [31:0]           p1_wdata,
  input  logic [3:0]            p1_wmask,
  output logic                  p1_ready,
  output logic [31:0]           rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  output logic                  mem_rstrb,
  input  logic [31:0]           mem_rdata
);

  state_t state, state_nxt;
  logic   grant;
  logic   last_grant;
  logic   winner;
  logic   any_req;
  logic   take;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;
  logic [3:0]            sel_wmask;

  assign any_req = p0_req || p1_req;
  assign take    = (state == ST_IDLE) && any_req;

  rr_pick2 u_pick (
    .req0       (p0_req),
    .req1       (p1_req),
    .last_grant (last_grant),
    .winner     (winner)
  );

  assign sel_addr  = winner ? p1_addr  : p0_addr;
  assign sel_wdata = winner ? p1_wdata : p0_wdata;
  assign sel_wmask = winner ? p1_wmask : p0_wmask;

  // The memory registers its read data, so it is simply forwarded in RESP.
  assign rdata = mem_rdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    p0_ready  = 1'b0;
    p1_ready  = 1'b0;
    unique case (state)
      ST_IDLE:   if (any_req) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP: begin
        p0_ready  = !grant;
        p1_ready  = grant;
        state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Memory strobes are registered: raised on the grant edge, dropped one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= WMASK_READ;
      mem_rstrb  <= 1'b0;
    end else if (take) begin
      grant      <= winner;
      last_grant <= winner;
      mem_addr   <= sel_addr;
      mem_wdata  <= sel_wdata;
      mem_wmask  <= sel_wmask;
      mem_rstrb  <= (sel_wmask == WMASK_READ);
    end else if (state == ST_ACCESS) begin
      mem_wmask  <= WMASK_READ;
      mem_rstrb  <= 1'b0;
    end
  end

endmodule
